// File: rtl/nms_window_reader.sv
// Raster-scans the score RAM and emits 3x3 score windows for the NMS datapath.
// Optional build macro WIN_ZERO_SKIP_EN suppresses windows whose centre score is zero.
module nms_window_reader #(
    parameter int unsigned IMG_W     = 181,
    parameter int unsigned IMG_H     = 181,
    parameter int unsigned ADDR_BASE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        mem_rd,
    output logic [14:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        win_valid,
    output logic [7:0]  ref_score,
    output logic [63:0] adj_score,
    output logic [14:0] ref_addr
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);
    localparam logic [XW-1:0] XTwo = XW'(2);
    localparam logic [YW-1:0] YTwo = YW'(2);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} stateT;

    stateT          state, stateNext;
    logic [XW-1:0]  xCnt;
    logic [YW-1:0]  yCnt;
    logic [14:0]    addrCnt;
    logic           drainCnt;
    logic           rdLast;

    // Stage 1: tags of the pixel whose data is on mem_data this cycle
    logic           rdVal1;
    logic [XW-1:0]  x1;
    logic [YW-1:0]  y1;
    logic [14:0]    addr1;

    logic [7:0]     lineBuf1 [IMG_W];
    logic [7:0]     lineBuf2 [IMG_W];
    logic [7:0]     winTop [2];
    logic [7:0]     winMid [2];
    logic [7:0]     winBot [2];

    logic [7:0]     topNew, midNew, centre;
    logic [63:0]    adjNext;
    logic           emit;

    assign rdLast = (state == StRead) && (xCnt == XLast) && (yCnt == YLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            StIdle:  if (start) stateNext = StRead;
            StRead:  if (rdLast) stateNext = StDrain;
            StDrain: if (drainCnt) stateNext = StFin;
            StFin:   stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state != StIdle);
        done     = (state == StFin);
        mem_rd   = (state == StRead);
        mem_addr = addrCnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xCnt     <= '0;
            yCnt     <= '0;
            addrCnt  <= '0;
            drainCnt <= 1'b0;
        end else begin
            drainCnt <= (state == StDrain) ? ~drainCnt : 1'b0;
            if (state == StIdle && start) begin
                xCnt    <= '0;
                yCnt    <= '0;
                addrCnt <= 15'(ADDR_BASE);
            end else if (state == StRead) begin
                addrCnt <= addrCnt + 15'd1;
                if (xCnt == XLast) begin
                    xCnt <= '0;
                    yCnt <= yCnt + 1'b1;
                end else begin
                    xCnt <= xCnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdVal1 <= 1'b0;
            x1     <= '0;
            y1     <= '0;
            addr1  <= '0;
        end else begin
            rdVal1 <= mem_rd;
            x1     <= xCnt;
            y1     <= yCnt;
            addr1  <= addrCnt;
        end
    end

    // Window columns before the shift: [0] is column x-2, [1] is column x-1
    always_comb begin
        topNew  = lineBuf2[x1];
        midNew  = lineBuf1[x1];
        centre  = winMid[1];
        adjNext = {winTop[0], winTop[1], topNew,
                   winMid[0], midNew,
                   winBot[0], winBot[1], mem_data};
`ifdef WIN_ZERO_SKIP_EN
        emit    = rdVal1 && (x1 >= XTwo) && (y1 >= YTwo) && (centre != 8'd0);
`else
        emit    = rdVal1 && (x1 >= XTwo) && (y1 >= YTwo);
`endif
    end

    // Storage is not reset: contents are only consumed once fully rewritten
    always_ff @(posedge clk) begin
        if (rdVal1) begin
            lineBuf2[x1] <= lineBuf1[x1];
            lineBuf1[x1] <= mem_data;
            winTop[0]    <= winTop[1];
            winTop[1]    <= topNew;
            winMid[0]    <= winMid[1];
            winMid[1]    <= midNew;
            winBot[0]    <= winBot[1];
            winBot[1]    <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
            ref_score <= '0;
            adj_score <= '0;
            ref_addr  <= '0;
        end else begin
            win_valid <= emit;
            if (emit) begin
                ref_score <= centre;
                adj_score <= adjNext;
                ref_addr  <= addr1;
            end
        end
    end

endmodule

// File: tb/tb_nms_window_reader.sv
// Directed/randomized bench for nms_window_reader with a RAM model and a window-list reference.
module tb_nms_window_reader;

    localparam int W = 5;
    localparam int H = 4;
    localparam int N = W * H;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, mem_rd, win_valid;
    logic [14:0] mem_addr, ref_addr;
    logic [7:0]  mem_data, ref_score;
    logic [63:0] adj_score;

    logic [7:0]  scoreMem [0:32767];

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  score;
        logic [63:0] adj;
    } winT;

    winT         expWin[$];
    logic [14:0] expAddr[$];

    int tests = 0;
    int failures = 0;

    // Results of the most recent frame
    int          winCount;
    int          lastReadCyc, lastWinCyc, doneCyc;
    logic [14:0] firstRefAddr, lastRefAddr;
    logic [7:0]  firstRefScore, lastRefScore;
    logic [63:0] firstAdj;
    bit          seenRef [0:N-1];

    nms_window_reader #(
        .IMG_W(W),
        .IMG_H(H),
        .ADDR_BASE(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .win_valid(win_valid),
        .ref_score(ref_score),
        .adj_score(adj_score),
        .ref_addr(ref_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= scoreMem[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] px(input int x, input int y);
        return scoreMem[15'(BASE + y * W + x)];
    endfunction

    task automatic buildExpected();
        winT w;
        expAddr.delete();
        expWin.delete();
        for (int i = 0; i < N; i++) expAddr.push_back(15'(BASE + i));
        for (int y = 2; y < H; y++) begin
            for (int x = 2; x < W; x++) begin
                w.addr  = 15'(BASE + y * W + x);
                w.score = px(x - 1, y - 1);
                w.adj   = {px(x - 2, y - 2), px(x - 1, y - 2), px(x, y - 2),
                           px(x - 2, y - 1), px(x, y - 1),
                           px(x - 2, y), px(x - 1, y), px(x, y)};
`ifdef WIN_ZERO_SKIP_EN
                if (w.score != 8'd0) expWin.push_back(w);
`else
                expWin.push_back(w);
`endif
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_mem_rd"}, {63'd0, mem_rd}, 64'd0);
        check({tag, "_mem_addr"}, {49'd0, mem_addr}, 64'd0);
        check({tag, "_win_valid"}, {63'd0, win_valid}, 64'd0);
        check({tag, "_ref_score"}, {56'd0, ref_score}, 64'd0);
        check({tag, "_adj_score"}, adj_score, 64'd0);
        check({tag, "_ref_addr"}, {49'd0, ref_addr}, 64'd0);
    endtask

    // Runs one frame; abortAt>0 asserts reset once that many reads have been seen
    task automatic runFrame(input string tag, input int abortAt, input bit midStart);
        int  cyc = 0;
        int  rdCnt = 0;
        int  winIdx = 0;
        int  doneCnt = 0;
        bit  fin = 0;
        buildExpected();
        for (int i = 0; i < N; i++) seenRef[i] = 0;
        lastReadCyc = -100;
        lastWinCyc  = -100;
        doneCyc     = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, {63'd0, busy}, 64'd1);
        while (!fin && cyc < 200) begin
            if (mem_rd) begin
                if (rdCnt < N)
                    check($sformatf("%s_addr%0d", tag, rdCnt), {49'd0, mem_addr},
                          {49'd0, expAddr[rdCnt]});
                else
                    check({tag, "_extra_read"}, 64'd1, 64'd0);
                rdCnt++;
                lastReadCyc = cyc;
            end
            if (win_valid) begin
                if (winIdx < expWin.size()) begin
                    check($sformatf("%s_win%0d_addr", tag, winIdx), {49'd0, ref_addr},
                          {49'd0, expWin[winIdx].addr});
                    check($sformatf("%s_win%0d_score", tag, winIdx), {56'd0, ref_score},
                          {56'd0, expWin[winIdx].score});
                    check($sformatf("%s_win%0d_adj", tag, winIdx), adj_score,
                          expWin[winIdx].adj);
                end else begin
                    check({tag, "_extra_window"}, 64'd1, 64'd0);
                end
                if (winIdx == 0) begin
                    firstRefAddr  = ref_addr;
                    firstRefScore = ref_score;
                    firstAdj      = adj_score;
                end
                lastRefAddr  = ref_addr;
                lastRefScore = ref_score;
                if (ref_addr < 15'(N)) seenRef[ref_addr] = 1;
                winIdx++;
                lastWinCyc = cyc;
            end
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
                fin = 1;
            end
            if (abortAt > 0 && rdCnt == abortAt) begin
                reset = 1'b1;
                #1;
                checkAllZero({tag, "_abort"});
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check($sformatf("%s_abort_nodone%0d", tag, k), {63'd0, done}, 64'd0);
                end
                reset = 1'b0;
                @(negedge clk);
                checkAllZero({tag, "_after_abort"});
                return;
            end
            start = (midStart && cyc == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        winCount = winIdx;
        check({tag, "_finished"}, {63'd0, fin}, 64'd1);
        check({tag, "_read_count"}, 64'(rdCnt), 64'(N));
        check({tag, "_reads_consecutive"}, 64'(lastReadCyc), 64'(N - 1));
        check({tag, "_window_count"}, 64'(winIdx), 64'(expWin.size()));
        check({tag, "_done_count"}, 64'(doneCnt), 64'd1);
        check({tag, "_done_timing"}, 64'(doneCyc), 64'(lastReadCyc + 3));
        @(negedge clk);
        check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_idle_done"}, {63'd0, done}, 64'd0);
    endtask

    task automatic fillSeq();
        for (int i = 0; i < N; i++) scoreMem[15'(BASE + i)] = 8'(i + 1);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < N; i++)
            scoreMem[15'(BASE + i)] = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
    endtask

    task automatic fillCentre();
        for (int i = 0; i < N; i++) scoreMem[15'(BASE + i)] = 8'd0;
        scoreMem[15'(BASE + 2 * W + 2)] = 8'h40;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("idle_no_start");

        fillSeq();
        runFrame("seq", 0, 1'b0);
        check("seq_windows", 64'(winCount), 64'd6);
        check("seq_first_score", {56'd0, firstRefScore}, 64'd7);
        check("seq_first_adj", firstAdj, 64'h0102_0306_080B_0C0D);
        check("seq_first_addr", {49'd0, firstRefAddr}, 64'd12);
        check("seq_last_score", {56'd0, lastRefScore}, 64'd14);
        check("seq_last_addr", {49'd0, lastRefAddr}, 64'd19);
        check("seq_done_after_last_win", 64'(doneCyc), 64'(lastWinCyc + 1));
        check("seq_nowrap_15", {63'd0, seenRef[15]}, 64'd0);
        check("seq_nowrap_16", {63'd0, seenRef[16]}, 64'd0);
        check("seq_hold_score", {56'd0, ref_score}, 64'd14);

        runFrame("abort", 9, 1'b0);
        runFrame("seq_again", 0, 1'b0);
        check("seq_again_first_addr", {49'd0, firstRefAddr}, 64'd12);

        runFrame("midstart", 0, 1'b1);

        for (int r = 0; r < 3; r++) begin
            fillRandom();
            runFrame($sformatf("rand%0d", r), 0, 1'b0);
        end

        fillCentre();
        runFrame("centre", 0, 1'b0);
`ifdef WIN_ZERO_SKIP_EN
        check("centre_windows", 64'(winCount), 64'd1);
        check("centre_addr", {49'd0, firstRefAddr}, 64'd18);
        check("centre_score", {56'd0, firstRefScore}, 64'h40);
`else
        check("centre_windows", 64'(winCount), 64'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
